if_fetch_queue: RTL and testbench



---
 rtl/if_fetch_queue_pkg.sv | 14 +
 rtl/if_fetch_queue_sync_fifo.sv | 71 +++++++
 rtl/if_fetch_queue.sv | 126 ++++++++++++
 tb/tb_if_fetch_queue.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package if_fetch_queue_pkg;

  localparam int          PC_W             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One queued fetch result: PC on top, instruction word below.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; head entry is readable combinationally.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_eff, pop_eff;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign rdata    = mem_q[rd_ptr_q];
  assign push_eff = push && !full && !flush;
  assign pop_eff  = pop && !empty && !flush;

  // Pointer and occupancy next-state; flush discards everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, response
// queue toward ID, and redirect handling with stale-response dropping.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     instr_id_out,
  output logic [PC_W-1:0] pc_id_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            active_q;

  logic [CW:0]     credit_used;
  logic            grant;
  logic            push, pop;
  logic [PC_W-1:0] redirect_pc_al;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    fifo_wdata, fifo_head;

  // Requests are held off for the first cycle after reset so imem_req is
  // low while in reset, and whenever queued plus in-flight work fills DEPTH.
  always_comb begin
    credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    imem_req       = active_q && !redirect && (credit_used < (CW+1)'(DEPTH));
    imem_addr      = fetch_pc_q;
    grant          = imem_req && imem_gnt;
    redirect_pc_al = redirect_pc & ~32'h3;
    push           = imem_rvalid && (drop_q == '0) && !redirect;
    pop            = !fifo_empty && id_ready && !redirect;
    fifo_wdata     = '{pc: resp_pc_q, instr: imem_rdata};
  end

  // PC, credit and drop bookkeeping; redirect overrides everything.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    case ({grant, imem_rvalid})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push)  resp_pc_d  = resp_pc_q + 32'd4;
    if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);

    // Every response still owed after this cycle belongs to the old path,
    // including one arriving right now.
    if (redirect) begin
      fetch_pc_d = redirect_pc_al;
      resp_pc_d  = redirect_pc_al;
      drop_d     = outstanding_d;
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      active_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      active_q      <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rstn  (rstn),
    .flush (redirect),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ID outputs come straight from the queue head, NOP/0 when empty.
  always_comb begin
    id_valid     = !fifo_empty;
    instr_id_out = fifo_empty ? NOP_INSTR : fifo_head.instr;
    pc_id_out    = fifo_empty ? '0 : fifo_head.pc;
  end

  a_counters: assert property (@(posedge clk) disable iff (!rstn)
    (drop_q <= outstanding_q) && (outstanding_q <= CW'(DEPTH)) &&
    (fifo_count <= CW'(DEPTH)));

  a_no_push_full: assert property (@(posedge clk) disable iff (!rstn)
    !(push && fifo_full));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: in-order memory model, epoch-tagged scoreboard.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] instr_id_out;
  logic [31:0] pc_id_out;

  if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .instr_id_out (instr_id_out),
    .pc_id_out    (pc_id_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mem_t        mem_q[$];
  exp_t        exp_q[$];
  int          epoch = 0;
  logic [31:0] exp_fetch = 32'h0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_grants = 0;
  int          first_g = -1;
  int          first_v = -1;
  logic        last_idv, last_req;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, sample #1 later, update models, wait posedge.
  task automatic step(input bit gnt, input bit rdy, input bit redir,
                      input logic [31:0] rpc, input bit rv_en);
    mem_t it;
    exp_t e;
    @(negedge clk);
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (rv_en && mem_q.size() > 0) begin
      it = mem_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(it.addr);
      if (it.epoch == epoch && !redir) begin
        e.pc = it.addr; e.instr = mem_data(it.addr);
        exp_q.push_back(e);
      end
    end
    imem_gnt    = gnt;
    id_ready    = rdy;
    redirect    = redir;
    redirect_pc = redir ? rpc : 32'h0;
    #1;
    last_idv = id_valid;
    last_req = imem_req;
    if (redir) chk("req_in_redirect", 32'(imem_req), 32'd0);
    if (id_valid) begin
      if (first_v < 0) first_v = cyc;
      if (rdy && !redir) begin
        chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("id_pc", pc_id_out, e.pc);
          chk("id_instr", instr_id_out, e.instr);
        end
      end
    end else begin
      chk("idle_instr", instr_id_out, 32'h0000_0013);
      chk("idle_pc", pc_id_out, 32'h0);
    end
    if (imem_req && gnt) begin
      chk("req_addr", imem_addr, exp_fetch);
      it.addr = exp_fetch; it.epoch = epoch;
      mem_q.push_back(it);
      exp_fetch += 32'd4;
      n_grants++;
      if (first_g < 0) first_g = cyc;
    end
    if (redir) begin
      epoch++;
      exp_q.delete();
      exp_fetch = rpc & ~32'h3;
    end
    @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 24; i++) begin
      if (mem_q.size() == 0 && exp_q.size() == 0) break;
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    end
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("drain_idle", 32'(last_idv), 32'd0);
  endtask

  // Asynchronous reset in mid-cycle; outputs must react without a clock.
  task automatic apply_reset(input string tag);
    #2;
    rstn = 1'b0;
    imem_rvalid = 1'b0; imem_gnt = 1'b0; redirect = 1'b0; id_ready = 1'b0;
    #1;
    chk({tag, "_idv"}, 32'(id_valid), 32'd0);
    chk({tag, "_instr"}, instr_id_out, 32'h0000_0013);
    chk({tag, "_pc"}, pc_id_out, 32'h0);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    mem_q.delete();
    exp_q.delete();
    epoch++;
    exp_fetch = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    // Reset state.
    apply_reset("reset");

    // Streaming fetch with immediate consumption.
    first_g = -1; first_v = -1;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("first_valid_latency", 32'(first_v - first_g), 32'd2);
    drain();

    // ID stalled: credits cap fetches at DEPTH, then drain in order.
    apply_reset("reset2");
    n_grants = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("credit_cap", 32'(n_grants), 32'd4);
    chk("req_low_when_full", 32'(last_req), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    drain();

    // Three outstanding, redirect to a misaligned target.
    n_grants = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("three_outstanding", 32'(n_grants), 32'd3);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    chk("redir_target", exp_fetch, 32'h0000_0100);
    first_v = -1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    drain();

    // Redirect coinciding with a response and a pop.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_4000, 1'b1);
    chk("redir_pop_idv", 32'(last_idv), 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("post_redir_idv", 32'(last_idv), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    drain();

    // Grant stall, then redirect withdraws the pending request.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr, exp_fetch);
    end
    step(1'b0, 1'b1, 1'b1, 32'h2000_0046, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("post_stall_addr", imem_addr, 32'h2000_0044);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Reset mid-stream, then restart from RESET_PC.
    apply_reset("midreset");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
